truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
- Controller that sweeps a combinational N-input, 1-output logic function through all 2^N input combinations.
- Drives the function's inputs, waits a programmable settle time, then samples F into a truth-table register.
- Compares the result against an expected minterm mask and reports the mismatch count and the first failing index.
- Sits between a host (start/done handshake) and the `top`-style function under evaluation; used for self-checking of binary-representation blocks in hardware.

Parameters:
- N_IN, 3, number of function inputs; table width TBL_W = 2**N_IN.
- SETTLE, 2, extra wait cycles per vector before sampling (0 is legal).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a scan when the block is idle.
- abort  in  1  cancels a scan in progress.
- expected  in  TBL_W  expected minterm mask; bit i is F for input value i, with A as the MSB. Latched on start.
- f_in  in  1  function output F.
- abc_out  out  N_IN  registered input vector to the function; {A,B,C} = abc_out[2:0].
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse when a scan completes.
- table_out  out  TBL_W  captured truth table.
- mismatch  out  1  set if table_out != expected latch.
- fail_count  out  N_IN+1  number of mismatching entries.
- first_fail_idx  out  N_IN  lowest mismatching index; 0 when there is no mismatch.

Behaviour:
- Reset (synchronous; wins over everything, including mid-scan): state=IDLE; abc_out, busy, done, table_out, mismatch, fail_count and first_fail_idx all 0. No done pulse is produced.
- States: IDLE, WAIT, DONE.
- IDLE:
  - start=1 at an edge: latch expected; clear table_out, fail_count, mismatch and first_fail_idx; idx=0; abc_out=0; cnt=SETTLE; go to WAIT; busy=1 from the next cycle.
  - start=1 together with abort=1: abort wins, stay in IDLE.
- WAIT, on each edge:
  - If abort: go to IDLE; busy=0 next cycle; no done; partial table_out and counters hold.
  - Else if cnt!=0: cnt decrements.
  - Else (cnt==0):
    - table_out[idx]=f_in.
    - If f_in != exp[idx]: fail_count+1, mismatch=1; first_fail_idx=idx if this is the first failure.
    - If idx==TBL_W-1: go to DONE.
    - Else: idx+1, abc_out=idx+1, cnt=SETTLE.
- Timing per vector: each vector occupies exactly SETTLE+1 cycles. abc_out is stable for that whole window, and f_in is sampled in the last cycle of the window.
- Scan latency: busy is high for TBL_W*(SETTLE+1) cycles. done is high for the single cycle after that, with busy=0.
- DONE: done=1 for one cycle, then IDLE. Results hold until the next start or reset.
- start while busy or in DONE: ignored.
- idx wrap: idx never wraps; the last vector is always TBL_W-1.
- abc_out after a completed scan: holds TBL_W-1 until the next start.

Decomposition:
- Package truth_table_pkg holds:
  - the state typedef (IDLE/WAIT/DONE);
  - function tbl_w(n) returning 2**n;
  - the default constants for N_IN and SETTLE.
- Optional sub-module settle_counter: load value, decrement, zero flag; parameterised width clog2(SETTLE+1).
- Everything else stays in one module.

Test Plan:
- Reset with reset=1 for 2 cycles → all outputs 0, busy=0, abc_out=0.
- Majority model F=(A&B)|(A&C)|(B&C), expected=8'hE8, SETTLE=2 → abc_out=3'b011 is held for 3 cycles with F=1 sampled; busy lasts 24 cycles, then done=1 for 1 cycle; table_out=8'hE8, mismatch=0, fail_count=0.
- Same model, expected=8'hE0 → table_out=8'hE8, mismatch=1, fail_count=1, first_fail_idx=3.
- SETTLE=0, model F=~A (8'h0F), expected=8'h0F → busy lasts exactly 8 cycles, abc_out steps 0..7 one per cycle, table_out=8'h0F, done pulses once.
- start pulsed again mid-scan → ignored, and the scan still completes on schedule. A separate run with abort at abc_out=4 → busy=0 next cycle, no done, table_out[3:0] holds the captured values.
- reset asserted at abc_out=5 → next cycle all outputs 0, state IDLE. A following start completes a full, correct scan.

Source files
------------

// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared types, defaults and sizing helpers for the truth-table sequencer
package truth_table_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_N_IN   = 3;
  localparam int DEF_SETTLE = 2;

  function automatic int tbl_w(input int n);
    return 1 << n;
  endfunction

  // Keeps the counter at least one bit wide so SETTLE=0 still elaborates.
  function automatic int cnt_w(input int settle);
    return (settle > 0) ? $clog2(settle + 1) : 1;
  endfunction

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - loadable down-counter that paces each vector's settle window
module settle_counter
  import truth_table_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE,
  localparam int CW = cnt_w(SETTLE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps an N-input function, captures its truth table and checks it
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE,
  localparam int TBL_W = tbl_w(N_IN),
  localparam int CW    = cnt_w(SETTLE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [TBL_W-1:0]  expected,
  input  logic              f_in,
  output logic [N_IN-1:0]   abc_out,
  output logic              busy,
  output logic              done,
  output logic [TBL_W-1:0]  table_out,
  output logic              mismatch,
  output logic [N_IN:0]     fail_count,
  output logic [N_IN-1:0]   first_fail_idx
);

  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TBL_W - 1);

  state_t           state;
  logic [TBL_W-1:0] exp_q;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             sample;

  // abc_out doubles as the vector index; it is only ever advanced, never wrapped.
  assign sample   = (state == S_WAIT) && !abort && cnt_zero;
  assign cnt_load = ((state == S_IDLE) && start && !abort) ||
                    (sample && (abc_out != LAST_IDX));
  assign cnt_dec  = (state == S_WAIT) && !abort && !cnt_zero;

  settle_counter #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(CW'(SETTLE)),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      exp_q          <= '0;
      abc_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      table_out      <= '0;
      mismatch       <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            exp_q          <= expected;
            table_out      <= '0;
            fail_count     <= '0;
            mismatch       <= 1'b0;
            first_fail_idx <= '0;
            abc_out        <= '0;
            busy           <= 1'b1;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt_zero) begin
            table_out[abc_out] <= f_in;
            if (f_in != exp_q[abc_out]) begin
              fail_count <= fail_count + 1'b1;
              mismatch   <= 1'b1;
              if (fail_count == '0) begin
                first_fail_idx <= abc_out;
              end
            end
            if (abc_out == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              abc_out <= abc_out + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - directed self-checking bench for truth_table_sequencer
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start2, abort2, start0, abort0;
  logic [7:0] exp2, exp0;
  logic       f2, f0;
  logic [2:0] abc2, abc0;
  logic       busy2, done2, mm2, busy0, done0, mm0;
  logic [7:0] tbl2, tbl0;
  logic [3:0] fc2, fc0;
  logic [2:0] ffi2, ffi0;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Majority function on the SETTLE=2 instance, F=~A on the SETTLE=0 instance.
  assign f2 = (abc2[2] & abc2[1]) | (abc2[2] & abc2[0]) | (abc2[1] & abc2[0]);
  assign f0 = ~abc0[2];

  truth_table_sequencer #(.N_IN(3), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2), .expected(exp2),
    .f_in(f2), .abc_out(abc2), .busy(busy2), .done(done2), .table_out(tbl2),
    .mismatch(mm2), .fail_count(fc2), .first_fail_idx(ffi2)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0), .expected(exp0),
    .f_in(f0), .abc_out(abc0), .busy(busy0), .done(done0), .table_out(tbl0),
    .mismatch(mm0), .fail_count(fc0), .first_fail_idx(ffi0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic check_idle2(input string tag);
    check({tag, "_busy"}, busy2, 0);
    check({tag, "_done"}, done2, 0);
    check({tag, "_abc"}, abc2, 0);
    check({tag, "_tbl"}, tbl2, 0);
    check({tag, "_mm"}, mm2, 0);
    check({tag, "_fc"}, fc2, 0);
    check({tag, "_ffi"}, ffi2, 0);
  endtask

  initial begin
    int cyc;
    int abc3_cyc;
    int done_cnt;
    int steps_ok;

    reset = 1'b1; start2 = 1'b0; abort2 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    exp2 = 8'h00; exp0 = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle2("reset");
    check("reset_busy0", busy0, 0);
    check("reset_abc0", abc0, 0);

    // start together with abort stays idle
    start2 = 1'b1; abort2 = 1'b1; exp2 = 8'hE8;
    @(negedge clk);
    start2 = 1'b0; abort2 = 1'b0;
    check("start_abort_busy", busy2, 0);

    // Majority, matching expectation
    start2 = 1'b1; exp2 = 8'hE8;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0; abc3_cyc = 0;
    while (busy2 && cyc < 200) begin
      if (abc2 == 3'd3) abc3_cyc++;
      cyc++;
      @(negedge clk);
    end
    check("maj_busy_cycles", cyc, 24);
    check("maj_abc3_hold", abc3_cyc, 3);
    check("maj_done", done2, 1);
    check("maj_tbl", tbl2, 8'hE8);
    check("maj_mm", mm2, 0);
    check("maj_fc", fc2, 0);
    check("maj_abc_end", abc2, 7);
    @(negedge clk);
    check("maj_done_pulse", done2, 0);

    // Majority against E0, with a stray start mid-scan carrying a different mask
    start2 = 1'b1; exp2 = 8'hE0;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 200) begin
      if (cyc == 10) begin start2 = 1'b1; exp2 = 8'hFF; end
      else start2 = 1'b0;
      cyc++;
      @(negedge clk);
    end
    start2 = 1'b0;
    check("e0_busy_cycles", cyc, 24);
    check("e0_done", done2, 1);
    check("e0_tbl", tbl2, 8'hE8);
    check("e0_mm", mm2, 1);
    check("e0_fc", fc2, 1);
    check("e0_ffi", ffi2, 3);

    // SETTLE=0, F=~A
    @(negedge clk);
    start0 = 1'b1; exp0 = 8'h0F;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 0; steps_ok = 1; done_cnt = 0;
    while (busy0 && cyc < 200) begin
      if (abc0 != 3'(cyc)) steps_ok = 0;
      if (done0) done_cnt++;
      cyc++;
      @(negedge clk);
    end
    check("s0_busy_cycles", cyc, 8);
    check("s0_abc_steps", steps_ok, 1);
    check("s0_tbl", tbl0, 8'h0F);
    check("s0_mm", mm0, 0);
    repeat (4) begin
      if (done0) done_cnt++;
      @(negedge clk);
    end
    check("s0_done_count", done_cnt, 1);

    // Abort when abc_out reaches 4
    start2 = 1'b1; exp2 = 8'hE8;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (abc2 != 3'd4 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("abort_reach_abc4", abc2, 4);
    abort2 = 1'b1;
    @(negedge clk);
    abort2 = 1'b0;
    check("abort_busy", busy2, 0);
    check("abort_tbl", tbl2, 8'h08);
    done_cnt = 0;
    repeat (5) begin
      if (done2 || busy2) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", done_cnt, 0);

    // Reset mid-scan at abc_out=5, then a clean full scan
    start2 = 1'b1; exp2 = 8'hE8;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (abc2 != 3'd5 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("rst_reach_abc5", abc2, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle2("midrst");
    start2 = 1'b1; exp2 = 8'hE8;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("post_rst_cycles", cyc, 24);
    check("post_rst_done", done2, 1);
    check("post_rst_tbl", tbl2, 8'hE8);
    check("post_rst_mm", mm2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
